// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX pipeline register with ALU-control decode, EX forwarding, stall and flush
module id_ex_operand_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [15:0]       id_imm16,
  input  logic [5:0]        id_funct,
  input  logic [1:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic              ex_mem_regwrite,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic [DATA_W-1:0] ex_mem_result,
  input  logic              mem_wb_regwrite,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic [DATA_W-1:0] mem_wb_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_control,
  output logic [DATA_W-1:0] ex_rt_fwd,
  output logic              illegal_funct
);
  logic              valid_q, valid_d, src_q, src_d, ill_q, ill_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d;
  logic [2:0]        ctrl_q, ctrl_d, funct_ctrl, dec_ctrl;
  logic              funct_bad, dec_ill;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;

  always_comb begin
    funct_ctrl = id_funct == 6'b100000 ? 3'b010 :
                 id_funct == 6'b100010 ? 3'b110 :
                 id_funct == 6'b100100 ? 3'b000 :
                 id_funct == 6'b100101 ? 3'b001 :
                 id_funct == 6'b101010 ? 3'b111 : 3'b011;
    funct_bad  = !(id_funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010});
    dec_ctrl   = id_alu_op == 2'b00 ? 3'b010 :
                 id_alu_op == 2'b01 ? 3'b110 :
                 id_alu_op == 2'b11 ? 3'b001 : funct_ctrl;
    dec_ill    = id_valid && id_alu_op == 2'b10 && funct_bad;
    valid_d    = flush ? 1'b0 : stall ? valid_q   : id_valid;
    rs_data_d  = flush ? '0   : stall ? rs_data_q : id_rs_data;
    rt_data_d  = flush ? '0   : stall ? rt_data_q : id_rt_data;
    rs_d       = flush ? '0   : stall ? rs_q      : id_rs;
    rt_d       = flush ? '0   : stall ? rt_q      : id_rt;
    imm_d      = flush ? '0   : stall ? imm_q     : {{(DATA_W-16){id_imm16[15]}}, id_imm16};
    src_d      = flush ? 1'b0 : stall ? src_q     : id_alu_src;
    ctrl_d     = flush ? 3'b0 : stall ? ctrl_q    : dec_ctrl;
    ill_d      = flush ? 1'b0 : stall ? ill_q     : dec_ill;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      imm_q     <= '0;
      src_q     <= 1'b0;
      ctrl_q    <= 3'b000;
      ill_q     <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      imm_q     <= imm_d;
      src_q     <= src_d;
      ctrl_q    <= ctrl_d;
      ill_q     <= ill_d;
    end
  end

  // EX/MEM outranks MEM/WB; register 0 is hardwired and never forwarded
  always_comb begin
    fwd_rs = (ex_mem_regwrite && ex_mem_rd != '0 && ex_mem_rd == rs_q) ? ex_mem_result :
             (mem_wb_regwrite && mem_wb_rd != '0 && mem_wb_rd == rs_q) ? mem_wb_data : rs_data_q;
    fwd_rt = (ex_mem_regwrite && ex_mem_rd != '0 && ex_mem_rd == rt_q) ? ex_mem_result :
             (mem_wb_regwrite && mem_wb_rd != '0 && mem_wb_rd == rt_q) ? mem_wb_data : rt_data_q;
  end

  assign ex_valid      = valid_q;
  assign alu_a         = fwd_rs;
  assign alu_b         = src_q ? imm_q : fwd_rt;
  assign ex_rt_fwd     = fwd_rt;
  assign alu_control   = ctrl_q;
  assign illegal_funct = ill_q;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed and randomized checks against a behavioural ID/EX model
module tb_id_ex_operand_stage;
  logic        clk, rst_n, stall, flush, id_valid, id_alu_src;
  logic [31:0] id_rs_data, id_rt_data, ex_mem_result, mem_wb_data;
  logic [4:0]  id_rs, id_rt, ex_mem_rd, mem_wb_rd;
  logic [15:0] id_imm16;
  logic [5:0]  id_funct;
  logic [1:0]  id_alu_op;
  logic        ex_mem_regwrite, mem_wb_regwrite;
  logic        ex_valid, illegal_funct;
  logic [31:0] alu_a, alu_b, ex_rt_fwd;
  logic [2:0]  alu_control;

  int checks = 0;
  int errors = 0;

  logic        m_valid, m_src, m_ill;
  logic [31:0] m_rs_data, m_rt_data, m_imm;
  logic [4:0]  m_rs, m_rt;
  logic [2:0]  m_ctrl;

  id_ex_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_rs(id_rs), .id_rt(id_rt),
    .id_imm16(id_imm16), .id_funct(id_funct), .id_alu_op(id_alu_op), .id_alu_src(id_alu_src),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_rd(ex_mem_rd), .ex_mem_result(ex_mem_result),
    .mem_wb_regwrite(mem_wb_regwrite), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .ex_rt_fwd(ex_rt_fwd), .illegal_funct(illegal_funct)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] decode(input logic [1:0] op, input logic [5:0] f);
    case (op)
      2'b00: return 4'b0010;
      2'b01: return 4'b0110;
      2'b11: return 4'b0001;
      default: case (f)
        6'b100000: return 4'b0010;
        6'b100010: return 4'b0110;
        6'b100100: return 4'b0000;
        6'b100101: return 4'b0001;
        6'b101010: return 4'b0111;
        default:   return 4'b1011;
      endcase
    endcase
  endfunction

  function automatic logic [31:0] fwd(input logic [4:0] s, input logic [31:0] r);
    if (s == 0) return r;
    if (ex_mem_regwrite && ex_mem_rd == s) return ex_mem_result;
    if (mem_wb_regwrite && mem_wb_rd == s) return mem_wb_data;
    return r;
  endfunction

  task automatic model_clear();
    {m_valid, m_src, m_ill, m_rs_data, m_rt_data, m_imm, m_rs, m_rt, m_ctrl} = '0;
  endtask

  task automatic model_edge();
    logic [3:0] d;
    d = decode(id_alu_op, id_funct);
    if (!rst_n) model_clear();
    else if (flush) model_clear();
    else if (!stall) begin
      m_valid = id_valid; m_rs_data = id_rs_data; m_rt_data = id_rt_data;
      m_rs = id_rs; m_rt = id_rt; m_src = id_alu_src;
      m_imm = 32'($signed(id_imm16));
      m_ctrl = d[2:0]; m_ill = id_valid && d[3];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, 32'(ex_valid), 32'(m_valid));
    chk({tag, ".a"}, alu_a, fwd(m_rs, m_rs_data));
    chk({tag, ".b"}, alu_b, m_src ? m_imm : fwd(m_rt, m_rt_data));
    chk({tag, ".rtfwd"}, ex_rt_fwd, fwd(m_rt, m_rt_data));
    chk({tag, ".ctrl"}, 32'(alu_control), 32'(m_ctrl));
    chk({tag, ".ill"}, 32'(illegal_funct), 32'(m_ill));
  endtask

  task automatic set_id(input logic v, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm,
                        input logic [5:0] f, input logic [1:0] op, input logic src);
    id_valid = v; id_rs_data = a; id_rt_data = b; id_rs = s; id_rt = t;
    id_imm16 = imm; id_funct = f; id_alu_op = op; id_alu_src = src;
  endtask

  logic [5:0] legal [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    set_id(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
    ex_mem_regwrite = 1'b0; ex_mem_rd = '0; ex_mem_result = '0;
    mem_wb_regwrite = 1'b0; mem_wb_rd = '0; mem_wb_data = '0;
    model_clear();
    #2;
    check_all("reset");
    rst_n = 1'b1;

    set_id(1'b1, 32'd5, 32'd7, 5'd1, 5'd2, 16'h0000, 6'b100000, 2'b10, 1'b0);
    step();
    chk("add.a", alu_a, 32'd5);
    chk("add.b", alu_b, 32'd7);
    chk("add.ctrl", 32'(alu_control), 32'd2);
    chk("add.valid", 32'(ex_valid), 32'd1);
    check_all("add");

    set_id(1'b1, 32'd100, 32'd0, 5'd1, 5'd2, 16'hFFFC, 6'b000000, 2'b00, 1'b1);
    step();
    chk("immneg.b", alu_b, 32'hFFFF_FFFC);
    chk("immneg.ctrl", 32'(alu_control), 32'd2);
    chk("immneg.a", alu_a, 32'd100);

    set_id(1'b1, 32'h11, 32'h22, 5'd3, 5'd0, 16'h0000, 6'b000000, 2'b00, 1'b0);
    step();
    ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd3; ex_mem_result = 32'hAA;
    mem_wb_regwrite = 1'b1; mem_wb_rd = 5'd3; mem_wb_data = 32'hBB;
    #1 chk("fwd.exmem", alu_a, 32'hAA);
    chk("fwd.rt0", ex_rt_fwd, 32'h22);
    ex_mem_regwrite = 1'b0;
    #1 chk("fwd.memwb", alu_a, 32'hBB);
    ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd0; mem_wb_rd = 5'd0;
    #1 chk("fwd.rd0", alu_a, 32'h11);
    check_all("fwd");
    ex_mem_regwrite = 1'b0; mem_wb_regwrite = 1'b0;

    set_id(1'b1, 32'd9, 32'd4, 5'd5, 5'd6, 16'h0000, 6'b101010, 2'b10, 1'b0);
    step();
    chk("slt.ctrl", 32'(alu_control), 32'd7);
    stall = 1'b1;
    set_id(1'b1, 32'd1, 32'd2, 5'd7, 5'd8, 16'h1234, 6'b100000, 2'b10, 1'b1);
    step();
    chk("stall.ctrl", 32'(alu_control), 32'd7);
    chk("stall.a", alu_a, 32'd9);
    chk("stall.b", alu_b, 32'd4);
    check_all("stall");
    flush = 1'b1;
    step();
    chk("flush.valid", 32'(ex_valid), 32'd0);
    chk("flush.ctrl", 32'(alu_control), 32'd0);
    check_all("flush");
    stall = 1'b0; flush = 1'b0;

    set_id(1'b1, 32'd3, 32'd4, 5'd1, 5'd2, 16'h0000, 6'b000111, 2'b10, 1'b0);
    step();
    chk("illegal.ctrl", 32'(alu_control), 32'd3);
    chk("illegal.flag", 32'(illegal_funct), 32'd1);
    set_id(1'b1, 32'd3, 32'd4, 5'd1, 5'd2, 16'h0000, 6'b100000, 2'b10, 1'b0);
    step();
    chk("legal.flag", 32'(illegal_funct), 32'd0);
    check_all("legal");

    set_id(1'b1, 32'hDEAD, 32'hBEEF, 5'd4, 5'd5, 16'h8001, 6'b100101, 2'b10, 1'b1);
    step();
    #2 rst_n = 1'b0;
    model_clear();
    #1 chk("arst.valid", 32'(ex_valid), 32'd0);
    chk("arst.a", alu_a, 32'd0);
    chk("arst.b", alu_b, 32'd0);
    check_all("arst");
    #1 rst_n = 1'b1;

    for (int i = 0; i < 300; i++) begin
      set_id(1'($urandom), 32'($urandom), 32'($urandom), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 16'($urandom),
             ($urandom_range(0, 3) == 0) ? 6'($urandom) : legal[$urandom_range(0, 4)],
             2'($urandom), 1'($urandom));
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      step();
      ex_mem_regwrite = 1'($urandom); ex_mem_rd = 5'($urandom_range(0, 3)); ex_mem_result = 32'($urandom);
      mem_wb_regwrite = 1'($urandom); mem_wb_rd = 5'($urandom_range(0, 3)); mem_wb_data = 32'($urandom);
      #1 check_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
